// File: rtl/multicycle_controller.sv
// Moore main controller for the RV32I multicycle core.
// Sequences fetch/decode/execute/memory/writeback, stalls on mem_ready, traps illegal opcodes.
module multicycle_controller #(
  parameter int MEM_WAIT        = 1,
  parameter int HALT_ON_ILLEGAL = 1,
  parameter int CNT_W           = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       opcode,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             ir_write,
  output logic             branch,
  output logic             mem_read,
  output logic             mem_write,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [1:0]       result_src,
  output logic             reg_write,
  output logic             illegal,
  output logic             retire,
  output logic [CNT_W-1:0] retire_cnt,
  output logic [3:0]       state
);

  typedef enum logic [3:0] {
    S_BOOT     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_MEM_ADDR = 4'd3,
    S_MEM_RD   = 4'd4,
    S_MEM_WB   = 4'd5,
    S_MEM_WR   = 4'd6,
    S_EXEC_R   = 4'd7,
    S_EXEC_I   = 4'd8,
    S_ALU_WB   = 4'd9,
    S_BRANCH   = 4'd10,
    S_JAL      = 4'd11,
    S_TRAP     = 4'd12
  } state_t;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_ST  = 7'b0100011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam bit P_WAIT = (MEM_WAIT != 0);
  localparam bit P_HALT = (HALT_ON_ILLEGAL != 0);

  state_t           r_state;
  state_t           w_next;
  state_t           w_dec;
  logic [CNT_W-1:0] r_cnt;
  logic             w_rdy;
  logic             w_is_r;
  logic             w_is_i;
  logic             w_is_ld;
  logic             w_is_st;
  logic             w_is_br;
  logic             w_is_jal;

  assign w_rdy    = P_WAIT ? mem_ready : 1'b1;
  assign w_is_r   = (opcode == OP_R);
  assign w_is_i   = (opcode == OP_I);
  assign w_is_ld  = (opcode == OP_LD);
  assign w_is_st  = (opcode == OP_ST);
  assign w_is_br  = (opcode == OP_BR);
  assign w_is_jal = (opcode == OP_JAL);

  always_comb begin
    w_dec = S_TRAP;
    unique case (1'b1)
      w_is_r:             w_dec = S_EXEC_R;
      w_is_i:             w_dec = S_EXEC_I;
      w_is_ld, w_is_st:   w_dec = S_MEM_ADDR;
      w_is_br:            w_dec = S_BRANCH;
      w_is_jal:           w_dec = S_JAL;
      default:            w_dec = S_TRAP;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_BOOT;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next     = r_state;
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    branch     = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    result_src = 2'b00;
    reg_write  = 1'b0;
    illegal    = 1'b0;
    retire     = 1'b0;
    unique case (r_state)
      S_BOOT: begin
        w_next = S_FETCH;
      end
      S_FETCH: begin
        mem_read   = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        pc_write   = w_rdy;
        ir_write   = w_rdy;
        if (w_rdy) w_next = S_DECODE;
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        w_next    = w_dec;
      end
      S_MEM_ADDR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        w_next    = w_is_ld ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        mem_read = 1'b1;
        if (w_rdy) w_next = S_MEM_WB;
      end
      S_MEM_WB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
        retire     = 1'b1;
        w_next     = S_FETCH;
      end
      S_MEM_WR: begin
        mem_write = 1'b1;
        retire    = w_rdy;
        if (w_rdy) w_next = S_FETCH;
      end
      S_EXEC_R: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b10;
        w_next    = S_ALU_WB;
      end
      S_EXEC_I: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op    = 2'b10;
        w_next    = S_ALU_WB;
      end
      S_ALU_WB: begin
        reg_write = 1'b1;
        retire    = 1'b1;
        w_next    = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b01;
        branch    = 1'b1;
        retire    = 1'b1;
        w_next    = S_FETCH;
      end
      S_JAL: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_write  = 1'b1;
        w_next    = S_ALU_WB;
      end
      S_TRAP: begin
        illegal = 1'b1;
        w_next  = P_HALT ? S_TRAP : S_FETCH;
      end
      default: begin
        w_next = S_TRAP;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (retire) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign retire_cnt = r_cnt;
  assign state      = r_state;

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Moore-FSM main controller for the RV32I multicycle core.
- Successor to the single-cycle opcode decoder: sequences fetch/decode/execute/memory/writeback over several cycles.
- Stalls on a memory ready handshake, traps illegal opcodes and counts retired instructions.
- Sits between the instruction register (opcode field) and the multicycle datapath/memory interface.

Parameters:
- MEM_WAIT, 1, 1 = honour mem_ready (variable-latency memory); 0 = treat mem_ready as constant 1.
- HALT_ON_ILLEGAL, 1, 1 = TRAP is terminal until reset; 0 = TRAP lasts one cycle, then FETCH.
- CNT_W, 32, width of retire_cnt.

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  reset, asynchronous, active-low
- opcode  input  7  instr[6:0] from the instruction register
- mem_ready  input  1  memory completes the current read/write this cycle
- pc_write  output  1  PC register load enable
- ir_write  output  1  instruction register / old-PC load enable
- branch  output  1  conditional PC load (datapath ANDs with ALU zero)
- mem_read  output  1  memory read request
- mem_write  output  1  memory write request
- alu_src_a  output  2  00 PC, 01 oldPC, 10 rs1
- alu_src_b  output  2  00 rs2, 01 imm, 10 const 4
- alu_op  output  2  00 add, 01 sub, 10 funct-decoded
- result_src  output  2  00 ALUOut reg, 01 mem data, 10 ALU result
- reg_write  output  1  register-file write enable
- illegal  output  1  high while in TRAP
- retire  output  1  one-cycle pulse per retired instruction
- retire_cnt  output  CNT_W  retired-instruction count
- state  output  4  current state encoding (debug)

Behaviour:
- State encodings: BOOT=0, FETCH=1, DECODE=2, MEM_ADDR=3, MEM_RD=4, MEM_WB=5, MEM_WR=6, EXEC_R=7, EXEC_I=8, ALU_WB=9, BRANCH=10, JAL=11, TRAP=12. Encodings 13-15 go to TRAP.
- Reset: state=BOOT; every output is 0, including retire_cnt.
- Outputs are a function of state only (Moore). Exceptions: pc_write, ir_write and retire, which are also qualified by mem_ready where listed. Any output not listed for a state is 0.
- "rdy" below means mem_ready when MEM_WAIT=1, and constant 1 when MEM_WAIT=0.
- BOOT: all outputs 0 -> FETCH.
- FETCH:
  - mem_read=1, a=00, b=10, op=00, result_src=10.
  - pc_write=ir_write=rdy.
  - Stay in FETCH while !rdy; go to DECODE on rdy.
- DECODE: a=01, b=01, op=00 (branch target into ALUOut). Next state by opcode:
  - 0110011 -> EXEC_R
  - 0010011 -> EXEC_I
  - 0000011 or 0100011 -> MEM_ADDR
  - 1100011 -> BRANCH
  - 1101111 -> JAL
  - anything else -> TRAP
- MEM_ADDR: a=10, b=01, op=00. Go to MEM_RD if the opcode is a load, else MEM_WR. The opcode is held stable by the IR.
- MEM_RD: mem_read=1, result_src=00. Wait for rdy, then go to MEM_WB.
- MEM_WB: result_src=01, reg_write=1, retire=1 -> FETCH.
- MEM_WR: mem_write=1, result_src=00. Wait for rdy. retire=rdy. Then go to FETCH.
- EXEC_R: a=10, b=00, op=10 -> ALU_WB.
- EXEC_I: a=10, b=01, op=10 -> ALU_WB.
- ALU_WB: result_src=00, reg_write=1, retire=1 -> FETCH.
- BRANCH: a=10, b=00, op=01, result_src=00, branch=1, retire=1 -> FETCH.
- JAL: a=01, b=10, op=00, result_src=00, pc_write=1 -> ALU_WB. The link value is written in ALU_WB; the retire happens there.
- TRAP: illegal=1.
  - HALT_ON_ILLEGAL=1: remain in TRAP until reset.
  - HALT_ON_ILLEGAL=0: go to FETCH next cycle. No retire.
- retire_cnt: increments by 1 on every cycle where retire=1. Wraps modulo 2^CNT_W.
- Asynchronous reset mid-instruction: the state and counter clear immediately, and all strobes drop in the same instant.
- Exactly one of mem_read and mem_write may be high in any cycle.
- reg_write and mem_write are never high together.

Test Plan:
- Reset, then R-type (0110011) with MEM_WAIT=0 -> states 0,1,2,7,9,1. reg_write is high only in ALU_WB. retire_cnt goes 0->1.
- Load (0000011), mem_ready low for 3 cycles in FETCH and 2 cycles in MEM_RD -> FETCH holds 4 cycles with pc_write=0 until ready. Sequence is 2,3,4(x3),5. reg_write with result_src=01 occurs once.
- Store (0100011) -> MEM_WR asserts mem_write until mem_ready. No reg_write. One retire pulse.
- Branch (1100011) followed by JAL (1101111) -> BRANCH gives branch=1, op=01. JAL gives pc_write=1, then ALU_WB gives reg_write=1. retire_cnt +2.
- Opcode 1111111 -> TRAP. With HALT_ON_ILLEGAL=1, illegal stays 1 for 10 cycles and nothing retires. With HALT_ON_ILLEGAL=0, illegal pulses 1 cycle, then FETCH.
- CNT_W=4, 16 retired R-types -> retire_cnt wraps 15->0. Assert rst_n=0 mid-MEM_RD -> outputs and the counter are 0 asynchronously, and the block restarts from BOOT.
